// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The control unit is the master: it observes Opcode/MemReady and drives
// every datapath strobe plus the retired-instruction count.
interface multicycle_control_unit_if #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
);
    logic [6:0]         Opcode;
    logic               MemReady;
    logic               PCWrite;
    logic               IRWrite;
    logic               Branch;
    logic               MemRead;
    logic               MemWrite;
    logic               MemToReg;
    logic               ALUSrc;
    logic               RegWrite;
    logic [ALUOP_W-1:0] ALUOp;
    logic               Illegal;
    logic [CNT_W-1:0]   Retired;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, IRWrite, Branch, MemRead, MemWrite, MemToReg,
               ALUSrc, RegWrite, ALUOp, Illegal, Retired
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, IRWrite, Branch, MemRead, MemWrite, MemToReg,
               ALUSrc, RegWrite, ALUOp, Illegal, Retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-style control unit: FETCH -> DECODE -> EXECUTE -> MEM -> WB.
// State, latched opcode and retired counter are registered; datapath strobes
// are decoded from the current state and latched opcode, with the FETCH/MEM
// completion strobes qualified by the MemReady handshake.
module multicycle_control_unit #(
    parameter int ALUOP_W      = 2,
    parameter int ENABLE_ITYPE = 1,
    parameter int CNT_W        = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_control_unit_if.master    bus
);

    if (ALUOP_W < 2) begin : g_bad_aluop_w
        $error("multicycle_control_unit: ALUOP_W must be at least 2");
    end

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB
    } state_t;

    state_t             state;
    logic [6:0]         opcode_q;
    logic [CNT_W-1:0]   retired_q;

    logic               pc_write, ir_write, branch, mem_read, mem_write;
    logic               mem_to_reg, alu_src, reg_write, illegal;
    logic [ALUOP_W-1:0] alu_op;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH: is_legal = 1'b1;
            OP_ITYPE:                               is_legal = (ENABLE_ITYPE != 0);
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    // Decode classes of the instruction latched in DECODE; the live Opcode
    // input is ignored outside DECODE.
    logic is_rtype, is_itype, is_load, is_store, is_branch, retire;
    assign is_rtype  = (opcode_q == OP_RTYPE);
    assign is_itype  = (opcode_q == OP_ITYPE);
    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);

    // An instruction completes on a branch EXECUTE, a handshaken store MEM,
    // or any WB cycle.
    assign retire = ((state == S_EXECUTE) && is_branch)
                 || ((state == S_MEM) && is_store && bus.MemReady)
                 ||  (state == S_WB);

    // State sequencing, opcode latch and retired-instruction counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state)
                S_FETCH: begin
                    if (bus.MemReady) state <= S_DECODE;
                end
                S_DECODE: begin
                    opcode_q <= bus.Opcode;
                    state    <= is_legal(bus.Opcode) ? S_EXECUTE : S_FETCH;
                end
                S_EXECUTE: begin
                    if (is_branch)                  state <= S_FETCH;
                    else if (is_load || is_store)   state <= S_MEM;
                    else if (is_rtype || is_itype)  state <= S_WB;
                    else                            state <= S_FETCH;
                end
                S_MEM: begin
                    if (bus.MemReady) state <= is_load ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Datapath strobe decode; reset suppresses everything but FETCH's MemRead.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_op     = ALU_ADD;
        if (reset) begin
            mem_read = (state == S_FETCH);
        end else begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (bus.MemReady) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: illegal = !is_legal(bus.Opcode);
                S_EXECUTE: begin
                    if (is_rtype) begin
                        alu_op = ALU_FUNCT;
                    end else if (is_itype) begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                    end else if (is_load || is_store) begin
                        alu_src = 1'b1;
                    end else if (is_branch) begin
                        branch = 1'b1;
                        alu_op = ALU_SUB;
                    end
                end
                S_MEM: begin
                    mem_read  = is_load;
                    mem_write = is_store;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_load;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWrite  = pc_write;
    assign bus.IRWrite  = ir_write;
    assign bus.Branch   = branch;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.MemToReg = mem_to_reg;
    assign bus.ALUSrc   = alu_src;
    assign bus.RegWrite = reg_write;
    assign bus.ALUOp    = alu_op;
    assign bus.Illegal  = illegal;
    assign bus.Retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. dut_a uses default parameters;
// dut_b disables I-type, widens ALUOp to 3 bits and shrinks Retired to 3 bits.
// Outputs are packed {PCWrite,IRWrite,MemRead,MemWrite,Branch,ALUSrc,
// RegWrite,MemToReg,Illegal,ALUOp} and compared at the falling edge.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_X  = 7'b1111111;

    localparam logic [10:0] V_FRDY = 11'b11100000000;
    localparam logic [10:0] V_MRD  = 11'b00100000000;
    localparam logic [10:0] V_IDLE = 11'b00000000000;
    localparam logic [10:0] V_ILL  = 11'b00000000100;
    localparam logic [10:0] V_EXR  = 11'b00000000010;
    localparam logic [10:0] V_EXI  = 11'b00000100010;
    localparam logic [10:0] V_EXLS = 11'b00000100000;
    localparam logic [10:0] V_EXBR = 11'b00001000001;
    localparam logic [10:0] V_MST  = 11'b00010000000;
    localparam logic [10:0] V_WBL  = 11'b00000011000;
    localparam logic [10:0] V_WB   = 11'b00000010000;

    typedef struct packed {
        logic [6:0]  op;
        logic        mr;
        logic [10:0] exp;
    } step_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_ret_a = '0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALUOP_W(2), .CNT_W(32)) a_if ();
    multicycle_control_unit_if #(.ALUOP_W(3), .CNT_W(3))  b_if ();

    multicycle_control_unit #(.ALUOP_W(2), .ENABLE_ITYPE(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(rst_a), .bus(a_if.master)
    );
    multicycle_control_unit #(.ALUOP_W(3), .ENABLE_ITYPE(0), .CNT_W(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(b_if.master)
    );

    function automatic logic [10:0] pack_a();
        return {a_if.PCWrite, a_if.IRWrite, a_if.MemRead, a_if.MemWrite, a_if.Branch,
                a_if.ALUSrc, a_if.RegWrite, a_if.MemToReg, a_if.Illegal, a_if.ALUOp};
    endfunction

    function automatic logic [11:0] pack_b();
        return {b_if.PCWrite, b_if.IRWrite, b_if.MemRead, b_if.MemWrite, b_if.Branch,
                b_if.ALUSrc, b_if.RegWrite, b_if.MemToReg, b_if.Illegal, b_if.ALUOp};
    endfunction

    function automatic logic [11:0] widen(input logic [10:0] v);
        return {v[10:2], 1'b0, v[1:0]};
    endfunction

    task automatic drive_a(input logic [6:0] op, input logic mr);
        a_if.Opcode = op;
        a_if.MemReady = mr;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic [6:0] op, input logic mr);
        b_if.Opcode = op;
        b_if.MemReady = mr;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_if.Opcode = OP_R; a_if.MemReady = 1'b1; rst_a = 1'b1;
        b_if.Opcode = OP_X; b_if.MemReady = 1'b0; rst_b = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive_a(OP_R, 1'b1);
            checks++;
            if (pack_a() !== V_MRD) begin
                $display("FAIL reset_outputs[%0d]: got %b want %b", i, pack_a(), V_MRD);
                errors++;
            end
            checks++;
            if (a_if.Retired !== 32'd0) begin
                $display("FAIL reset_retired[%0d]: got %0d want 0", i, a_if.Retired);
                errors++;
            end
            next_cycle();
        end
        rst_a = 1'b0;
        exp_ret_a = '0;
    endtask

    task automatic run_a(input string name, input step_t s[], input int inc);
        logic [31:0] start = exp_ret_a;
        for (int i = 0; i < s.size(); i++) begin
            drive_a(s[i].op, s[i].mr);
            checks++;
            if (pack_a() !== s[i].exp) begin
                $display("FAIL %s[%0d]: got %b want %b", name, i, pack_a(), s[i].exp);
                errors++;
            end
            next_cycle();
        end
        exp_ret_a = start + 32'(inc);
        checks++;
        if (a_if.Retired !== exp_ret_a) begin
            $display("FAIL %s_retired: got %0d want %0d", name, a_if.Retired, exp_ret_a);
            errors++;
        end
    endtask

    task automatic test_rtype();
        step_t s[] = '{'{OP_X, 1'b1, V_FRDY}, '{OP_R, 1'b1, V_IDLE},
                       '{OP_X, 1'b1, V_EXR},  '{OP_X, 1'b1, V_WB}};
        run_a("rtype", s, 1);
    endtask

    task automatic test_load_wait();
        step_t s[] = '{'{OP_X, 1'b1, V_FRDY}, '{OP_LD, 1'b1, V_IDLE},
                       '{OP_X, 1'b0, V_EXLS}, '{OP_X, 1'b0, V_MRD},
                       '{OP_X, 1'b0, V_MRD},  '{OP_X, 1'b1, V_MRD},
                       '{OP_X, 1'b0, V_WBL}};
        run_a("load_wait", s, 1);
    endtask

    task automatic test_store_branch();
        step_t s[] = '{'{OP_X, 1'b1, V_FRDY}, '{OP_ST, 1'b1, V_IDLE},
                       '{OP_X, 1'b1, V_EXLS}, '{OP_X, 1'b1, V_MST},
                       '{OP_X, 1'b1, V_FRDY}, '{OP_BR, 1'b1, V_IDLE},
                       '{OP_X, 1'b1, V_EXBR}};
        run_a("store_branch", s, 2);
    endtask

    task automatic test_itype_fetch_wait();
        step_t s[] = '{'{OP_X, 1'b0, V_MRD},  '{OP_LD, 1'b0, V_MRD},
                       '{OP_X, 1'b1, V_FRDY}, '{OP_I, 1'b0, V_IDLE},
                       '{OP_X, 1'b0, V_EXI},  '{OP_X, 1'b0, V_WB}};
        run_a("itype_fetch_wait", s, 1);
    endtask

    task automatic test_illegal_a();
        step_t s[] = '{'{OP_R, 1'b1, V_FRDY}, '{OP_X, 1'b1, V_ILL},
                       '{OP_R, 1'b0, V_MRD}};
        run_a("illegal_a", s, 0);
    endtask

    task automatic test_reset_mid_load();
        step_t s[] = '{'{OP_X, 1'b1, V_FRDY}, '{OP_LD, 1'b1, V_IDLE},
                       '{OP_X, 1'b0, V_EXLS}, '{OP_X, 1'b0, V_MRD}};
        logic [10:0] v;
        run_a("abort_pre", s, 0);
        rst_a = 1'b1;
        drive_a(OP_X, 1'b0);
        v = pack_a();
        checks++;
        if ({v[10], v[9], v[7], v[4]} !== 4'b0000) begin
            $display("FAIL abort_strobes: got %b want no write strobes", v);
            errors++;
        end
        next_cycle();
        drive_a(OP_X, 1'b1);
        checks++;
        if (pack_a() !== V_MRD || a_if.Retired !== 32'd0) begin
            $display("FAIL abort_in_reset: got %b ret %0d want %b ret 0",
                     pack_a(), a_if.Retired, V_MRD);
            errors++;
        end
        next_cycle();
        rst_a = 1'b0;
        exp_ret_a = '0;
        begin
            step_t t[] = '{'{OP_X, 1'b0, V_MRD}, '{OP_X, 1'b0, V_MRD}};
            run_a("abort_post", t, 0);
        end
    endtask

    task automatic test_illegal_b();
        step_t s[] = '{'{OP_X, 1'b1, V_FRDY}, '{OP_I, 1'b1, V_ILL},
                       '{OP_R, 1'b1, V_FRDY}, '{OP_X, 1'b1, V_ILL},
                       '{OP_R, 1'b0, V_MRD}};
        rst_b = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            drive_b(s[i].op, s[i].mr);
            checks++;
            if (pack_b() !== widen(s[i].exp)) begin
                $display("FAIL illegal_b[%0d]: got %b want %b", i, pack_b(), widen(s[i].exp));
                errors++;
            end
            next_cycle();
        end
        checks++;
        if (b_if.Retired !== 3'd0) begin
            $display("FAIL illegal_b_retired: got %0d want 0", b_if.Retired);
            errors++;
        end
    endtask

    task automatic test_back_to_back_wrap();
        step_t s[] = '{'{OP_X, 1'b1, V_FRDY}, '{OP_BR, 1'b1, V_IDLE},
                       '{OP_X, 1'b1, V_EXBR}};
        logic [2:0] want = 3'd0;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 3; i++) begin
                drive_b(s[i].op, s[i].mr);
                checks++;
                if (pack_b() !== widen(s[i].exp)) begin
                    $display("FAIL wrap_b[%0d.%0d]: got %b want %b", k, i, pack_b(), widen(s[i].exp));
                    errors++;
                end
                next_cycle();
            end
            want = 3'((k + 1) % 8);
            checks++;
            if (b_if.Retired !== want) begin
                $display("FAIL wrap_b_retired[%0d]: got %0d want %0d", k, b_if.Retired, want);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_itype_fetch_wait();
        test_illegal_a();
        test_reset_mid_load();
        test_illegal_b();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
